mem_arb: RTL and testbench

- Two-requester arbiter placed in front of mem_sys (cache + SDRAM controller).
- Shares the single mem_sys port between the instruction-fetch requester (read-only) and the data requester (read/write).
- Sequences mem_sys's valid/wr/rd/done handshake and returns read data plus a one-cycle done pulse to the granted requester.
- Data port has priority. A streak counter prevents fetch starvation.

---
 rtl/mem_arb.sv | 163 ++++++++++++++++
 tb/tb_mem_arb.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb.sv
// Two-requester arbiter (fetch read-only, data read/write) in front of mem_sys.
// Define MEM_ARB_TIMEOUT_EN to add a done watchdog and the sticky timeout_err output.
module mem_arb #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  output logic              m_wr,
  output logic              m_rd,
  output logic              m_valid,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_done,
  input  logic              m_init_done,
  output logic              busy
`ifdef MEM_ARB_TIMEOUT_EN
  ,
  output logic              timeout_err
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RELEASE} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_D} owner_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_D_STREAK);
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
`endif

  // Every register lives here so reset is a single '0 (IDLE / OWN_NONE encode as 0).
  typedef struct packed {
    state_t            state;
    owner_t            owner;
    logic [3:0]        streak;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              wr;
    logic              rd;
    logic              valid;
    logic [DATA_W-1:0] if_rdata;
    logic [DATA_W-1:0] d_rdata;
    logic              if_done;
    logic              d_done;
`ifdef MEM_ARB_TIMEOUT_EN
    logic [CNT_W-1:0]  cnt;
    logic              terr;
`endif
  } regs_t;

  regs_t r, rn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r <= '0;
    else        r <= rn;
  end

  always_comb begin
    rn         = r;
    rn.if_done = 1'b0;
    rn.d_done  = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    rn.cnt     = '0;
`endif
    case (r.state)
      S_IDLE: begin
        if (m_init_done) begin
          if (d_req && !(if_req && r.streak == STREAK_MAX)) begin
            rn.addr   = d_addr;
            rn.wdata  = d_wdata;
            rn.wr     = d_wr;
            rn.rd     = !d_wr;
            rn.valid  = 1'b1;
            rn.owner  = OWN_D;
            rn.streak = !if_req ? 4'd0 :
                        (r.streak == STREAK_MAX) ? r.streak : r.streak + 4'd1;
            rn.state  = S_BUSY;
          end else if (if_req) begin
            rn.addr   = if_addr;
            rn.wdata  = '0;
            rn.wr     = 1'b0;
            rn.rd     = 1'b1;
            rn.valid  = 1'b1;
            rn.owner  = OWN_IF;
            rn.streak = 4'd0;
            rn.state  = S_BUSY;
          end
        end
      end
      S_BUSY: begin
`ifdef MEM_ARB_TIMEOUT_EN
        rn.cnt = r.cnt + 1'b1;
`endif
        if (m_done) begin
          rn.valid = 1'b0;
          rn.wr    = 1'b0;
          rn.rd    = 1'b0;
          rn.state = S_RELEASE;
          if (r.owner == OWN_IF) begin
            rn.if_rdata = m_rdata;
            rn.if_done  = 1'b1;
          end else begin
            if (!r.wr) rn.d_rdata = m_rdata;
            rn.d_done = 1'b1;
          end
        end
`ifdef MEM_ARB_TIMEOUT_EN
        // Give up after TIMEOUT cycles of m_valid; the owner sees zero data.
        else if (r.cnt == CNT_W'(TIMEOUT - 1)) begin
          rn.valid = 1'b0;
          rn.wr    = 1'b0;
          rn.rd    = 1'b0;
          rn.terr  = 1'b1;
          rn.state = S_RELEASE;
          if (r.owner == OWN_IF) begin
            rn.if_rdata = '0;
            rn.if_done  = 1'b1;
          end else begin
            rn.d_rdata = '0;
            rn.d_done  = 1'b1;
          end
        end
`endif
      end
      S_RELEASE: begin
        // mem_sys may hold done for several cycles; wait for it to fall.
        if (!m_done) begin
          rn.state = S_IDLE;
          rn.owner = OWN_NONE;
        end
      end
      default: rn.state = S_IDLE;
    endcase
  end

  assign m_addr   = r.addr;
  assign m_wdata  = r.wdata;
  assign m_wr     = r.wr;
  assign m_rd     = r.rd;
  assign m_valid  = r.valid;
  assign if_rdata = r.if_rdata;
  assign d_rdata  = r.d_rdata;
  assign if_done  = r.if_done;
  assign d_done   = r.d_done;
  assign busy     = (r.state != S_IDLE);
`ifdef MEM_ARB_TIMEOUT_EN
  assign timeout_err = r.terr;
`endif

endmodule

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb: vector table for single transactions plus
// hand sequences for init gating, sticky done, anti-starvation, reset and timeout.
module tb_mem_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
  logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic [31:0] if_rdata, d_rdata, m_addr, m_wdata;
  logic        if_done, d_done, m_wr, m_rd, m_valid, busy;
  logic [31:0] m_rdata = '0;
  logic        m_done = 1'b0;
  logic        m_init_done = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
  logic        timeout_err;
`endif

  mem_arb #(.ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(4), .TIMEOUT(100)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_done(d_done),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_wr(m_wr), .m_rd(m_rd), .m_valid(m_valid),
    .m_rdata(m_rdata), .m_done(m_done), .m_init_done(m_init_done), .busy(busy)
`ifdef MEM_ARB_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // mem_sys model: done after lat cycles of m_valid, held high for hold cycles
  int          lat = 0, hold = 1, mcnt = 0, hl = 0;
  bit          hang = 1'b0;
  logic [31:0] resp = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      m_done = 1'b0; mcnt = 0; hl = 0;
    end else if (m_done) begin
      hl--;
      if (hl <= 0) m_done = 1'b0;
    end else if (m_valid && !hang) begin
      if (mcnt >= lat) begin
        m_done = 1'b1; m_rdata = resp; hl = hold; mcnt = 0;
      end else mcnt++;
    end else mcnt = 0;
  end

  int both_cnt = 0, done_total = 0;
  always @(negedge clk) begin
    #1;
    if (if_done && d_done) both_cnt++;
    done_total += int'(if_done) + int'(d_done);
  end

  task automatic wait_valid(output bit ok, output int n);
    ok = 1'b0; n = 0;
    for (int i = 0; i < 60; i++) begin
      tick(); n++;
      if (m_valid) begin ok = 1'b1; return; end
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (if_done || d_done) begin ok = 1'b1; return; end
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (!busy) return;
      tick();
    end
    chk("idle_timeout", busy, 0);
  endtask

  typedef struct {
    logic        if_req, d_req, d_wr;
    logic [31:0] if_addr, d_addr, d_wdata, resp;
    int          lat, hold;
    logic [31:0] e_addr, e_wdata;
    logic        e_wr, e_rd, e_d;
    logic [31:0] e_if_rdata, e_d_rdata;
  } vec_t;

  vec_t vt[5];

  initial begin
    bit ok;
    int n, gap, snap;
    bit bad;
    logic [31:0] ca, cw;
    logic cwr, crd;
    byte seq[$];
    byte exp_seq[10];

    vt[0] = '{1, 0, 0, 32'h0000_1000, 32'h0, 32'h0, 32'hA5A5_0001, 2, 1,
              32'h0000_1000, 32'h0, 0, 1, 0, 32'hA5A5_0001, 32'h0};
    vt[1] = '{0, 1, 1, 32'h0, 32'h0000_0104, 32'hDEAD_BEEF, 32'h5555_5555, 5, 1,
              32'h0000_0104, 32'hDEAD_BEEF, 1, 0, 1, 32'hA5A5_0001, 32'h0};
    vt[2] = '{0, 1, 0, 32'h0, 32'h0000_0200, 32'h9999_9999, 32'hCAFE_F00D, 0, 1,
              32'h0000_0200, 32'h9999_9999, 0, 1, 1, 32'hA5A5_0001, 32'hCAFE_F00D};
    vt[3] = '{0, 1, 1, 32'h0, 32'h0000_0300, 32'h0BAD_F00D, 32'h1111_1111, 1, 2,
              32'h0000_0300, 32'h0BAD_F00D, 1, 0, 1, 32'hA5A5_0001, 32'hCAFE_F00D};
    vt[4] = '{1, 0, 0, 32'h0000_2000, 32'h0, 32'h0, 32'h1234_5678, 3, 3,
              32'h0000_2000, 32'h0, 0, 1, 0, 32'h1234_5678, 32'hCAFE_F00D};

    // reset state and init gating
    tick(); tick();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_wr_rd", {m_wr, m_rd}, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_dones", {if_done, d_done}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdata", {if_rdata, d_rdata}, 0);
    rst_n = 1'b1;
    if_req = 1'b1; if_addr = 32'h0000_0040; lat = 0; hold = 1; resp = 32'h0000_00AA;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin tick(); if (m_valid || busy) bad = 1'b1; end
    chk("init_gate", bad, 0);
    m_init_done = 1'b1;
    tick();
    chk("init_valid", m_valid, 1);
    chk("init_rd", {m_wr, m_rd}, 2'b01);
    chk("init_addr", m_addr, 32'h0000_0040);
    wait_done(ok);
    chk("init_done", {ok, if_done, d_done}, 3'b110);
    chk("init_rdata", if_rdata, 32'h0000_00AA);
    if_req = 1'b0;
    wait_idle();

    // table-driven single transactions
    for (int v = 0; v < 5; v++) begin
      wait_idle();
      lat = vt[v].lat; hold = vt[v].hold; resp = vt[v].resp;
      if_req = vt[v].if_req; if_addr = vt[v].if_addr;
      d_req = vt[v].d_req; d_wr = vt[v].d_wr; d_addr = vt[v].d_addr; d_wdata = vt[v].d_wdata;
      wait_valid(ok, n);
      chk($sformatf("v%0d_latency", v), {ok, 8'(n)}, {1'b1, 8'd1});
      chk($sformatf("v%0d_addr", v), m_addr, vt[v].e_addr);
      chk($sformatf("v%0d_wdata", v), m_wdata, vt[v].e_wdata);
      chk($sformatf("v%0d_wr_rd", v), {m_wr, m_rd}, {vt[v].e_wr, vt[v].e_rd});
      ca = m_addr; cw = m_wdata; cwr = m_wr; crd = m_rd;
      bad = 1'b0; ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
        tick();
        if (if_done || d_done) begin ok = 1'b1; break; end
        if (!m_valid || m_addr != ca || m_wdata != cw || m_wr != cwr || m_rd != crd) bad = 1'b1;
      end
      chk($sformatf("v%0d_stable", v), bad, 0);
      chk($sformatf("v%0d_done_owner", v), {ok, d_done, if_done}, {1'b1, vt[v].e_d, !vt[v].e_d});
      chk($sformatf("v%0d_if_rdata", v), if_rdata, vt[v].e_if_rdata);
      chk($sformatf("v%0d_d_rdata", v), d_rdata, vt[v].e_d_rdata);
      chk($sformatf("v%0d_valid_drop", v), m_valid, 0);
      if_req = 1'b0; d_req = 1'b0;
      tick();
      chk($sformatf("v%0d_pulse_width", v), {if_done, d_done}, 0);
    end
    wait_idle();

    // sticky done: data request waiting behind a held m_done
    lat = 2; hold = 3; resp = 32'h8765_4321;
    if_req = 1'b1; if_addr = 32'h0000_3000;
    wait_done(ok);
    chk("sticky_if_done", {ok, if_done}, 2'b11);
    chk("sticky_if_rdata", if_rdata, 32'h8765_4321);
    if_req = 1'b0;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h0000_0400; resp = 32'h0F0F_0F0F; hold = 1;
    gap = 0; bad = 1'b0; ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (if_done) bad = 1'b1;
      if (m_valid) begin ok = 1'b1; break; end
      if (!m_done) gap++;
    end
    chk("sticky_single_pulse", bad, 0);
    chk("sticky_regrant_gap", {ok, 8'(gap)}, {1'b1, 8'd2});
    wait_done(ok);
    chk("sticky_d_done", {ok, d_done}, 2'b11);
    chk("sticky_d_rdata", d_rdata, 32'h0F0F_0F0F);
    d_req = 1'b0;
    wait_idle();

    // anti-starvation: both held continuously
    exp_seq = '{"D", "D", "D", "D", "F", "D", "D", "D", "D", "F"};
    lat = 1; hold = 1; resp = 32'h0000_5A5A;
    if_addr = 32'h0000_0600; d_addr = 32'h0000_0500; d_wr = 1'b0;
    if_req = 1'b1; d_req = 1'b1;
    for (int i = 0; i < 400 && seq.size() < 10; i++) begin
      tick();
      if (d_done) seq.push_back("D");
      else if (if_done) seq.push_back("F");
    end
    if_req = 1'b0; d_req = 1'b0;
    chk("prio_count", seq.size(), 10);
    for (int i = 0; i < 10; i++)
      chk($sformatf("prio_grant%0d", i), (i < seq.size()) ? seq[i] : 8'h00, exp_seq[i]);
    chk("done_exclusive", both_cnt, 0);
    wait_idle();

    // asynchronous reset mid-transaction
    hang = 1'b1;
    d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h0000_0700; d_wdata = 32'h0000_0077;
    wait_valid(ok, n);
    chk("rst_mid_valid", ok, 1);
    tick(); tick();
    snap = done_total;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {m_valid, m_wr, m_rd, busy, if_done, d_done}, 0);
    chk("rst_mid_addr", {m_addr, m_wdata}, 0);
    chk("rst_mid_rdata", {if_rdata, d_rdata}, 0);
    tick(); tick(); tick();
    rst_n = 1'b1; hang = 1'b0; lat = 1;
    wait_valid(ok, n);
    chk("rst_regrant", {ok, m_wr}, 2'b11);
    chk("rst_regrant_addr", m_addr, 32'h0000_0700);
    chk("rst_no_stray_done", done_total, snap);
    wait_done(ok);
    chk("rst_regrant_done", {ok, d_done}, 2'b11);
    d_req = 1'b0;
    wait_idle();

`ifdef MEM_ARB_TIMEOUT_EN
    chk("to_err_clear", timeout_err, 0);
    hang = 1'b1;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h0000_0800;
    wait_valid(ok, n);
    n = 1;
    for (int i = 0; i < 300 && m_valid; i++) begin tick(); if (m_valid) n++; end
    chk("to_valid_cycles", n, 100);
    chk("to_d_done", {d_done, if_done}, 2'b10);
    chk("to_d_rdata", d_rdata, 0);
    chk("to_err_set", timeout_err, 1);
    d_req = 1'b0; hang = 1'b0;
    tick(); tick(); tick();
    chk("to_err_sticky", timeout_err, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got hang exp finish");
    $fatal(1, "timeout");
  end

endmodule
